// File: rtl/my_pkg.sv
// rtl/my_pkg.sv - shared types for the sequential EX-stage multiplier
package my_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } MulOp_Enum;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } MulSeqState_Enum;

    function automatic logic op1_is_signed(input MulOp_Enum op);
        return (op == MUL) || (op == MULH) || (op == MULHSU);
    endfunction

    function automatic logic op2_is_signed(input MulOp_Enum op);
        return (op == MUL) || (op == MULH);
    endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// rtl/mul_sign_fix.sv - applies the result sign to the magnitude product and selects the half
module mul_sign_fix
    import my_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc_i,
    input  logic              neg_i,
    input  MulOp_Enum         op_i,
    output logic [XLEN-1:0]   result_o
);

    logic [2*XLEN-1:0] prod;

    always_comb begin
        prod     = neg_i ? (-acc_i) : acc_i;
        result_o = (op_i == MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

endmodule

// File: rtl/ex_mul_seq.sv
// rtl/ex_mul_seq.sv - iterative shift-add multiplier for the EX stage
// Optional EX_MUL_SEQ_EARLY_OUT_EN ends RUN once the remaining multiplier is zero.
module ex_mul_seq
    import my_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            EN,
    input  logic            start,
    input  MulOp_Enum       op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    MulSeqState_Enum   state_q;
    MulOp_Enum         op_q;
    logic              neg_q;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   mplr_q, mplr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q;

    logic              s1, s2;
    logic [XLEN-1:0]   abs1, abs2;
    logic              run_exit;
    logic [XLEN-1:0]   fix_res;

    // Operands are reduced to magnitudes; the sign is reapplied once at the end.
    always_comb begin
        s1   = op1_is_signed(op) && op1[XLEN-1];
        s2   = op2_is_signed(op) && op2[XLEN-1];
        abs1 = s1 ? (-op1) : op1;
        abs2 = s2 ? (-op2) : op2;
    end

    always_comb begin
        acc_d    = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_d  = mcand_q << 1;
        mplr_d   = mplr_q >> 1;
        cnt_d    = cnt_q + 1'b1;
`ifdef EX_MUL_SEQ_EARLY_OUT_EN
        run_exit = (cnt_q == LAST) || (mplr_d == '0);
`else
        run_exit = (cnt_q == LAST);
`endif
    end

    mul_sign_fix #(
        .XLEN(XLEN)
    ) u_sign_fix (
        .acc_i    (acc_d),
        .neg_i    (neg_q),
        .op_i     (op_q),
        .result_o (fix_res)
    );

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q  <= IDLE;
            op_q     <= MUL;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (EN) begin
            if (flush) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (start) begin
                        op_q    <= op;
                        neg_q   <= s1 ^ s2;
                        acc_q   <= '0;
                        mcand_q <= {{XLEN{1'b0}}, abs1};
                        mplr_q  <= abs2;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                    RUN: begin
                        acc_q   <= acc_d;
                        mcand_q <= mcand_d;
                        mplr_q  <= mplr_d;
                        cnt_q   <= cnt_d;
                        // Result is captured on the exit edge so it is stable throughout DONE.
                        if (run_exit) begin
                            result_q <= fix_res;
                            state_q  <= DONE;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE) && EN && !flush;
    assign stall  = !flush && (((state_q == IDLE) && start) || (state_q == RUN));
    assign result = result_q;

endmodule

// File: tb/tb_ex_mul_seq.sv
// tb/tb_ex_mul_seq.sv - scoreboard bench for ex_mul_seq with a plain-arithmetic reference
module tb_ex_mul_seq;
    import my_pkg::*;

    localparam int XLEN = 32;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        EN = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    MulOp_Enum   op = MUL;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        stall, busy, done;
    logic [31:0] result;

    int cyc = 0;
    int n_pass = 0;
    int n_tot = 0;

    typedef struct {
        logic [31:0] res;
        int          at;
    } exp_t;
    exp_t        sb[$];
    logic [31:0] last_exp = '0;

    ex_mul_seq #(.XLEN(XLEN)) dut (
        .CLK(CLK), .RSTn(RSTn), .EN(EN), .start(start), .op(op),
        .op1(op1), .op2(op2), .flush(flush), .stall(stall), .busy(busy),
        .done(done), .result(result)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Full-width product of the sign/zero-extended operands, then pick the half.
    function automatic logic [31:0] ref_mul(input MulOp_Enum o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] a64, b64, p;
        a64 = (o != MULHU && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
        b64 = ((o == MUL || o == MULH) && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
        p   = a64 * b64;
        return (o == MUL) ? p[31:0] : p[63:32];
    endfunction

    function automatic int ref_runs(input MulOp_Enum o, input logic [31:0] b);
        logic [31:0] m;
        int          n;
        m = ((o == MUL || o == MULH) && b[31]) ? (32'd0 - b) : b;
        n = XLEN;
`ifdef EX_MUL_SEQ_EARLY_OUT_EN
        n = 0;
        do begin
            n++;
            m = m >> 1;
        end while (m != 0 && n < XLEN);
`endif
        return n;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input MulOp_Enum o, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input int delay, input bit chk_stall);
        exp_t e;
        start = 1'b1; op = o; op1 = a; op2 = b;
        if (push) begin
            e.res = ref_mul(o, a, b);
            e.at  = cyc + ref_runs(o, b) + 1 + delay;
            sb.push_back(e);
            last_exp = e.res;
        end
        if (chk_stall) begin
            @(negedge CLK);
            chk("stall_accept", {31'd0, stall}, 32'd1);
        end
        step();
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0 && !busy) return;
            step();
        end
        chk("timeout", 32'd1, 32'd0);
        sb.delete();
    endtask

    MulOp_Enum   d_op[8]  = '{MULH, MULHU, MUL, MULHSU, MULH, MUL, MUL, MUL};
    logic [31:0] d_a[8]   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'd5, 32'd5, 32'h8000_0000};
    logic [31:0] d_b[8]   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                              32'hFFFF_FFFF, 32'd3, 32'd0, 32'hFFFF_FFFF};

    initial begin
        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge CLK);
                    if (done) begin
                        if (sb.size() == 0) begin
                            chk("spurious_done", 32'd1, 32'd0);
                        end else begin
                            e = sb.pop_front();
                            chk("result", result, e.res);
                            chk("done_cycle", cyc, e.at);
                        end
                    end
                end
            end
            begin : main
                int runs, bad;
                logic [31:0] ra, rb;
                MulOp_Enum   ro;

                step(); step();
                chk("rst_stall", {31'd0, stall}, 32'd0);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_done", {31'd0, done}, 32'd0);
                chk("rst_result", result, 32'd0);
                RSTn = 1'b1;
                step();

                // 7*6 with stall window across acceptance and RUN
                issue(MUL, 32'd7, 32'd6, 1'b1, 0, 1'b1);
                runs = ref_runs(MUL, 32'd6);
                bad = 0;
                for (int i = 0; i < runs; i++) begin
                    @(negedge CLK);
                    if (!stall) bad++;
                    step();
                end
                chk("stall_run", bad, 32'd0);
                @(negedge CLK);
                chk("stall_done", {31'd0, stall}, 32'd0);
                chk("done_pulse", {31'd0, done}, 32'd1);
                wait_done();
                repeat (3) step();
                chk("result_hold", result, last_exp);

                for (int i = 0; i < 8; i++) begin
                    issue(d_op[i], d_a[i], d_b[i], 1'b1, 0, 1'b0);
                    wait_done();
                end

                // flush in the 10th RUN cycle
                issue(MUL, 32'h1234, 32'h8055_0055, 1'b0, 0, 1'b0);
                repeat (9) step();
                flush = 1'b1;
                @(negedge CLK);
                chk("flush_stall", {31'd0, stall}, 32'd0);
                chk("flush_done", {31'd0, done}, 32'd0);
                step();
                flush = 1'b0;
                chk("flush_idle", {31'd0, busy}, 32'd0);
                issue(MUL, 32'd3, 32'd3, 1'b1, 0, 1'b0);
                wait_done();

                // EN low for 5 cycles mid-RUN
                issue(MULHU, 32'h1357_9BDF, 32'hDEAD_BEEF, 1'b1, 5, 1'b0);
                repeat (9) step();
                EN = 1'b0;
                repeat (5) step();
                EN = 1'b1;
                wait_done();

                for (int i = 0; i < 40; i++) begin
                    ro = MulOp_Enum'($urandom_range(0, 3));
                    ra = $urandom;
                    rb = $urandom;
                    case ($urandom_range(0, 5))
                        0: ra = 32'h8000_0000;
                        1: rb = 32'hFFFF_FFFF;
                        2: rb = $urandom_range(0, 15);
                        default: ;
                    endcase
                    issue(ro, ra, rb, 1'b1, 0, 1'b0);
                    wait_done();
                end

                // reset in the middle of RUN
                issue(MULH, 32'hDEAD_BEEF, 32'h8765_4321, 1'b0, 0, 1'b0);
                repeat (10) step();
                RSTn = 1'b0;
                step();
                chk("midrst_stall", {31'd0, stall}, 32'd0);
                chk("midrst_busy", {31'd0, busy}, 32'd0);
                chk("midrst_done", {31'd0, done}, 32'd0);
                chk("midrst_result", result, 32'd0);
                RSTn = 1'b1;
                repeat (3) step();
                chk("sb_drained", sb.size(), 32'd0);

                $display("%0d/%0d checks passed", n_pass, n_tot);
                $finish;
            end
        join
    end

endmodule

// File: doc/ex_mul_seq.md
EX_MUL_SEQ -- requirements
Module: ex_mul_seq

Interface
REQ-001 Parameter: XLEN, 32, operand/result width.
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 RSTn  input  1  reset; synchronous, active-low.
REQ-004 EN  input  1  pipeline enable; low freezes all state.
REQ-005 start  input  1  EX stage holds a valid multiply op.
REQ-006 op  input  2  MulOp_Enum: MUL, MULH, MULHSU, MULHU.
REQ-007 op1  input  XLEN  forwarded rs1 value.
REQ-008 op2  input  XLEN  forwarded rs2 value.
REQ-009 flush  input  1  kill in-flight op (branch/hazard flush).
REQ-010 stall  output  1  freeze IF/ID/EX to hazard logic.
REQ-011 busy  output  1  state != IDLE.
REQ-012 done  output  1  one-cycle pulse; result valid.
REQ-013 result  output  XLEN  multiply result.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, DONE; all transitions occur only when EN=1.
REQ-015 IDLE: start=1, flush=0 -> latch |op1|, |op2| per signedness (MUL/MULH: both signed; MULHSU: op1 signed; MULHU: none), latch result-negate flag and op, clear 2*XLEN accumulator, counter=0, go RUN.
REQ-016 RUN, per cycle: if multiplier bit0=1, accumulator += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter += 1.
REQ-017 RUN SHALL go DONE after exactly XLEN RUN cycles (counter = XLEN-1 on exit cycle).
REQ-018 DONE: done=1; result = low XLEN bits (MUL) or high XLEN bits (MULH*) of accumulator, two's-complement negated over 2*XLEN bits when negate flag set; next state IDLE.
REQ-019 Latency without early-out: accepted in cycle N -> done in cycle N+XLEN+1.
REQ-020 stall SHALL be (IDLE and start and not flush) or RUN, else 0; stall=0 in DONE so the pipeline advances that cycle.
REQ-021 flush=1 in any state -> next state IDLE, done=0 that cycle, stall=0 combinationally; flush dominates start.
REQ-022 result SHALL hold its last value outside DONE; done SHALL be 0 when EN=0.
REQ-023 Back-to-back ops: after DONE, a new start is accepted in the following IDLE cycle.
REQ-024 Arithmetic: signed minimum inputs handled via 2*XLEN product; MULH 0x80000000*0x80000000 = 0x40000000.

Reset
REQ-025 RSTn=0 at a rising CLK edge -> state IDLE, accumulator/operands/counter/flag 0, result 0, done 0, busy 0, stall 0, regardless of EN or mid-operation state.

Configuration
REQ-026 Macro EX_MUL_SEQ_EARLY_OUT_EN defined: RUN SHALL also go DONE at the end of any RUN cycle whose shifted multiplier becomes 0.
REQ-027 Macro undefined: RUN always lasts exactly XLEN cycles; results identical in both builds.

Structure
REQ-028 MulOp_Enum and MulSeqState_Enum SHALL live in my_pkg.
REQ-029 Sign fix-up and half select SHALL be a combinational sub-module mul_sign_fix.
REQ-030 Accumulator, multiplicand and multiplier registers SHALL stay in ex_mul_seq.

Verification
REQ-031 MUL 7*6 accepted cycle N -> result 42, done at N+33, stall high N..N+32.
REQ-032 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MUL -1*-1 -> 1.
REQ-033 MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF; MULH -1*-1 -> 0.
REQ-034 flush in 10th RUN cycle -> IDLE next cycle, stall 0 that cycle, no done; following MUL 3*3 -> 9.
REQ-035 EN low 5 cycles mid-RUN -> done delayed exactly 5 cycles, result unchanged; RSTn low mid-RUN -> all outputs 0 next cycle.
REQ-036 With EX_MUL_SEQ_EARLY_OUT_EN: MUL 5*3 accepted N -> done at N+3, result 15; MUL 5*0 -> done at N+2, result 0.
